// File: rtl/uart_pkg.sv
// Shared UART constants, the baud divider helper and the memory-dumper
// FSM state type. The boot programmer's receiver imports the same package
// so that framing constants stay in one place.
//
// Contents:
//   START_BIT, STOP_BIT   line levels of the framing bits
//   DATA_BITS             data bits per character (8N1)
//   dump_state_t          states of the memory dumper FSM
//   clks_per_bit()        integer-truncated clocks per serial bit
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    WAIT,
    CSUM,
    DONE
  } dump_state_t;

  // The result must be at least 4 for the transmitter timing to make sense.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_mem_dumper_if.sv
// Word-wide memory read port used by the memory dumper.
//
// Signals:
//   mem_addr   word-aligned byte address presented to memory
//   mem_re     read strobe, one cycle per word
//   mem_rdata  read data, valid exactly one cycle after mem_re
//
// Modports:
//   master  the dumper (drives address and strobe, takes data)
//   slave   the memory (takes address and strobe, returns data)
interface uart_mem_dumper_if;

  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_re, input mem_rdata);
  modport slave  (input mem_addr, input mem_re, output mem_rdata);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serial transmitter for one character at a time.
//
// Ports:
//   clk, rst_n  system clock and asynchronous active-low reset
//   tx_start    accepted while idle; loads tx_data and begins a frame
//   tx_data     character to send, LSB first
//   tx          serial line, idle high, registered
//   tx_busy     high while a frame is on the line
//   tx_done     high in the last cycle of the stop bit
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] frame;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  active;

  // The line is the bottom bit of the frame register, so an all-ones frame
  // is the idle level and reset drives the line high asynchronously.
  assign tx      = frame[0];
  assign tx_busy = active;
  assign tx_done = active && (bit_cnt == BIT_LAST) && (baud_cnt == BAUD_LAST);

  // Load start/data/stop as one word, then shift it out one bit per
  // CLKS_PER_BIT cycles, filling from the top with the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else if (!active) begin
      if (tx_start) begin
        frame    <= {STOP_BIT, tx_data, START_BIT};
        baud_cnt <= '0;
        bit_cnt  <= '0;
        active   <= 1'b1;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      if (bit_cnt == BIT_LAST) begin
        active <= 1'b0;
        frame  <= '1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        frame   <= {1'b1, frame[FRAME_BITS-1:1]};
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mem_dumper.sv
// Reads a block of 32-bit words from CPU memory and streams them out over
// the UART TX line, 8N1, little-endian byte order within each word.
//
// Optional feature: define UART_DUMP_CHECKSUM_EN to append one byte after
// the data, the sum modulo 256 of all data bytes sent in that dump.
//
// Ports:
//   clk, rst_n   system clock and asynchronous active-low reset
//   start        one-cycle dump request, honoured only while idle
//   base_addr    byte address of the first word (bits [1:0] ignored)
//   word_count   number of words to send, latched on start
//   mem          memory read port (master side)
//   tx           serial out, idle high
//   busy         high from the accepted start until done
//   done         one-cycle pulse at the end of a dump, busy already low
module uart_mem_dumper
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  uart_mem_dumper_if.master mem,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  dump_state_t      state;
  logic [31:0]      addr;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      shreg;
  logic [1:0]       byte_idx;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             tx_done;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // The current data byte is always the low byte of the shift register;
  // the checksum byte is sent from CSUM once the transmitter is free.
`ifdef UART_DUMP_CHECKSUM_EN
  assign tx_start = ((state == SEND) || (state == CSUM)) && !tx_busy;
  assign tx_data  = (state == CSUM) ? csum : shreg[7:0];
`else
  assign tx_start = (state == SEND) && !tx_busy;
  assign tx_data  = shreg[7:0];
`endif

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  // Dump sequencer. mem_re is raised on the transition into READ so it is
  // high for exactly the READ cycle, and the data is taken in LATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.mem_re   <= 1'b0;
      mem.mem_addr <= '0;
      addr         <= '0;
      remaining    <= '0;
      shreg        <= '0;
      byte_idx     <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      done       <= 1'b0;
      mem.mem_re <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr & ~32'h3;
            remaining <= word_count;
            busy      <= 1'b1;
`ifdef UART_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
            if (word_count == '0) begin
              state <= DONE;
            end else begin
              mem.mem_re   <= 1'b1;
              mem.mem_addr <= base_addr & ~32'h3;
              state        <= READ;
            end
          end
        end
        READ: begin
          state <= LATCH;
        end
        LATCH: begin
          shreg    <= mem.mem_rdata;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
`ifdef UART_DUMP_CHECKSUM_EN
            csum  <= csum + shreg[7:0];
`endif
            state <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              shreg    <= {8'h00, shreg[31:8]};
              state    <= SEND;
            end else begin
              remaining <= remaining - 1'b1;
              addr      <= addr + 32'd4;
              if (remaining != CNT_W'(1)) begin
                mem.mem_re   <= 1'b1;
                mem.mem_addr <= addr + 32'd4;
                state        <= READ;
              end else begin
`ifdef UART_DUMP_CHECKSUM_EN
                state <= CSUM;
`else
                state <= DONE;
`endif
              end
            end
          end
        end
`ifdef UART_DUMP_CHECKSUM_EN
        CSUM: begin
          if (tx_done) begin
            state <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_mem_dumper.md
Name: uart_mem_dumper

Overview:
- UART transmit-side companion to the boot programmer. Reads a block of 32-bit words from CPU memory and streams them out over serial TX, 8N1.
- Lets the host read back instruction or data memory after download or after a run, for verification.
- Sits beside the programmer in the top level. Shares the 50 MHz `clk` domain. `tx` is muxed onto the UART TX pin when `busy` is high.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer-truncated, must be ≥ 4.
- CNT_W, 16, width of the word-count input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- base_addr  input  32  byte address of first word; bits [1:0] ignored (treated as 0).
- word_count  input  CNT_W  number of words to send, latched on start.
- mem_addr  output  32  word-aligned byte address presented to memory.
- mem_re  output  1  read strobe, high one cycle per word.
- mem_rdata  input  32  read data, valid exactly 1 cycle after mem_re.
- tx  output  1  serial out, idle high.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse at end of dump.

Behaviour:
- Reset values: tx=1, busy=0, done=0, mem_re=0, mem_addr=0. All counters 0, FSM in IDLE.
- FSM states:
  - IDLE: start=1 latches base_addr & ~3 and word_count; busy=1 next cycle. If word_count=0 → DONE.
  - READ: mem_re=1 with mem_addr = current address, for one cycle.
  - LATCH: capture mem_rdata into a 32-bit shift register; byte index = 0.
  - SEND: pulse tx_start to the byte transmitter with byte[index]. Order is little-endian: bits [7:0] first.
  - WAIT: hold until tx_done.
    - Index < 3 → index+1, go to SEND.
    - Else decrement remaining words and add 4 to the address (32-bit wrap-around, 0xFFFFFFFC → 0x00000000).
    - Remaining > 0 → READ; else → DONE (or CSUM when enabled).
  - DONE: done=1 for one cycle, busy=0, → IDLE.
- Byte transmitter:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit held exactly CLKS_PER_BIT cycles.
  - tx_done asserts in the last cycle of the stop bit.
- Inter-byte gap: ≤2 idle-high cycles within a word, ≤4 cycles between words. No gap is inserted otherwise.
- start while busy: ignored. base_addr and word_count changes while busy: no effect.
- Reset mid-frame: tx returns high immediately (asynchronously); the truncated character is acceptable. FSM → IDLE, no done pulse.
- busy and done never both high in the same cycle. done is followed by busy=0 in that same cycle.

Optional Feature:
- Macro UART_DUMP_CHECKSUM_EN.
- Defined:
  - After the last data byte, the CSUM state sends one extra byte: the sum modulo 256 of all transmitted data bytes.
  - Then DONE.
  - The sum resets to 0 on each accepted start.
  - word_count=0 → no bytes and no checksum.
- Undefined: no CSUM state and no accumulator; DONE follows the last data byte.

Decomposition:
- Shared package `uart_pkg`:
  - function clks_per_bit(freq, baud)
  - localparams START_BIT=0, STOP_BIT=1, DATA_BITS=8
  - FSM state enum dump_state_t {IDLE, READ, LATCH, SEND, WAIT, CSUM, DONE}
- The programmer's receiver reuses the same package constants.
- One sub-module: `uart_tx_byte`. Ports: clk, rst_n, tx_start, tx_data[7:0], tx, tx_busy, tx_done. Owns the baud counter and bit counter.

Test Plan:
- All scenarios use CLK_FREQ=1000000, BAUD_RATE=100000 (10 clk/bit), with a behavioural memory returning mem[a] one cycle after mem_re.
- Single word: base_addr=0x0, count=1, mem[0]=0x12345678.
  - tx decodes bytes 78 56 34 12.
  - Every bit is exactly 10 cycles; done pulses once; busy falls in the same cycle.
- Multi-word with unaligned base: base_addr=0x13 (aligned to 0x10), count=3.
  - mem_addr sequence is 0x10, 0x14, 0x18.
  - 12 bytes received; inter-word gap ≤4 cycles.
- Zero count: start with count=0 → no tx edge; done exactly 2 cycles after start; busy high 1 cycle.
- Start while busy: second start pulse 50 cycles into a count=1 dump → ignored; only 4 bytes sent and one done pulse.
- Reset mid-frame: assert rst_n=0 during bit 3 of byte 1.
  - tx=1 in the same cycle; busy=0; no done.
  - A new start after release produces a correct full dump.
- Checksum (UART_DUMP_CHECKSUM_EN), with count=2:
  - mem[0]=0x000000FF, mem[1]=0x01010101.
  - Bytes FF 00 00 00 01 01 01 01, then checksum 0x03.
  - Without the macro, only the 8 data bytes are sent.
